// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Pipeline sequencer. It drives capture, hold and flush for the
//             IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, using the
//             fetch/data-memory handshakes, load-use hazards, branches, jumps
//             and HALT.
//  Options  : Define PIPE_CTRL_STATS_EN to add the saturating stall_cnt
//             statistics output, STAT_W bits wide.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
`ifdef PIPE_CTRL_STATS_EN
#(
  parameter int STAT_W = 32
)
`endif
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmemREN_EX_MEM,
  input  logic              dmemWEN_EX_MEM,
  input  logic              memread_ID_EX,
  input  logic [4:0]        rt_ID_EX,
  input  logic [4:0]        Rs_IF_ID,
  input  logic [4:0]        Rt_IF_ID,
  input  logic              branch_taken_EX,
  input  logic              jump_ID,
  input  logic              halt_MEM,
  output logic              pc_en,
  output logic              enable_IF_ID,
  output logic              enable_ID_EX,
  output logic              enable_EX_MEM,
  output logic              enable_MEM_WB,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
`ifdef PIPE_CTRL_STATS_EN
  output logic [STAT_W-1:0] stall_cnt,
`endif
  output logic              halt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t r_state;
  logic   r_dmem_done;
  logic   r_halt;

  logic   w_dreq;
  logic   w_dwait;
  logic   w_advance;
  logic   w_loaduse;
  logic   w_lu_bubble;

  assign w_dreq    = dmemREN_EX_MEM | dmemWEN_EX_MEM;
  // A completed access (dmem_done) must not stall again while waiting on ihit
  assign w_dwait   = w_dreq & ~dhit & ~r_dmem_done;
  assign w_advance = ihit & ~w_dwait & (r_state == RUN);
  assign w_loaduse = memread_ID_EX & (rt_ID_EX != 5'd0) &
                     ((rt_ID_EX == Rs_IF_ID) | (rt_ID_EX == Rt_IF_ID));
  // A taken branch squashes the dependent instruction, so no bubble is needed
  assign w_lu_bubble = w_advance & ~branch_taken_EX & w_loaduse;

  assign halt = r_halt;

  // Per-cycle capture/hold/flush decision; everything is held low during reset
  always_comb begin
    pc_en         = 1'b0;
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    if (nRST && w_advance) begin
      pc_en         = 1'b1;
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      if (branch_taken_EX) begin
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (w_loaduse) begin
        pc_en        = 1'b0;
        enable_IF_ID = 1'b0;
        flush_ID_EX  = 1'b1;
      end else if (jump_ID) begin
        flush_IF_ID = 1'b1;
      end
    end
  end

  // Sequencer state, data-access completion flag and sticky halt flag
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_dmem_done <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_advance && halt_MEM) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end else if (w_dwait) begin
            r_state <= DWAIT;
          end
        end
        DWAIT: begin
          if (dhit) r_state <= RUN;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
      // Advance consumes the completion, so it wins over a same-cycle dhit
      if (w_advance)   r_dmem_done <= 1'b0;
      else if (dhit)   r_dmem_done <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;
  logic              w_stall_inc;

  assign w_stall_inc = (~w_advance & (r_state != HALTED)) | w_lu_bubble;
  assign stall_cnt   = r_stall_cnt;

  // Saturating count of frozen cycles plus load-use bubbles
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {STAT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_lu_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Directed self-checking bench for pipe_ctrl_unit. Stall counter
//             checks are active when PIPE_CTRL_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, memread_ID_EX;
  logic [4:0] rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic       branch_taken_EX, jump_ID, halt_MEM;
  logic       pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic       flush_IF_ID, flush_ID_EX, halt;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, fl_IF_ID, fl_ID_EX}
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_ADV = 7'b1111100;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0011101;
  localparam logic [6:0] C_JMP = 7'b1111110;

  logic [6:0] w_ctrl;
  assign w_ctrl = {pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM,
                   enable_MEM_WB, flush_IF_ID, flush_ID_EX};

  always #5 CLK = ~CLK;

`ifdef PIPE_CTRL_STATS_EN
  pipe_ctrl_unit #(.STAT_W(4)) dut (
`else
  pipe_ctrl_unit dut (
`endif
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
    .memread_ID_EX(memread_ID_EX), .rt_ID_EX(rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID), .halt_MEM(halt_MEM),
    .pc_en(pc_en), .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
    .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
`ifdef PIPE_CTRL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .halt(halt)
  );

`ifndef PIPE_CTRL_STATS_EN
  assign stall_cnt = 4'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0;
    dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b0; memread_ID_EX = 1'b0;
    rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
    branch_taken_EX = 1'b0; jump_ID = 1'b0; halt_MEM = 1'b0;
    tick(); tick();

    // Reset state: outputs gated low even with ihit high
    chk("rst_ctrl", 32'(w_ctrl), 32'(C_FRZ));
    chk("rst_halt", 32'(halt), 32'd0);
`ifdef PIPE_CTRL_STATS_EN
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Plain advance
    nRST = 1'b1; #1;
    chk("adv0", 32'(w_ctrl), 32'(C_ADV));
    tick();
    chk("adv1", 32'(w_ctrl), 32'(C_ADV));
    chk("adv_halt", 32'(halt), 32'd0);

    // Load-use on Rs: one bubble cycle
    memread_ID_EX = 1'b1; rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5; #1;
    chk("lu_rs", 32'(w_ctrl), 32'(C_LU));
    tick();
    memread_ID_EX = 1'b0; #1;
    chk("lu_after", 32'(w_ctrl), 32'(C_ADV));
    // Destination $0 never stalls
    memread_ID_EX = 1'b1; rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0; #1;
    chk("lu_r0", 32'(w_ctrl), 32'(C_ADV));
    // Load-use on Rt
    rt_ID_EX = 5'd7; Rs_IF_ID = 5'd1; Rt_IF_ID = 5'd7; #1;
    chk("lu_rt", 32'(w_ctrl), 32'(C_LU));
    // Branch wins over load-use
    branch_taken_EX = 1'b1; #1;
    chk("br_lu", 32'(w_ctrl), 32'(C_BR));
    tick();
    branch_taken_EX = 1'b0; memread_ID_EX = 1'b0; jump_ID = 1'b1; #1;
    chk("jump", 32'(w_ctrl), 32'(C_JMP));
    tick();
    jump_ID = 1'b0;
`ifdef PIPE_CTRL_STATS_EN
    chk("cnt_lu", 32'(stall_cnt), 32'd1);
`endif
    // Fetch miss freezes everything
    ihit = 1'b0; #1;
    chk("imiss", 32'(w_ctrl), 32'(C_FRZ));
    ihit = 1'b1;

    // Clear counter, then a load that completes 3 cycles late
    nRST = 1'b0; tick(); nRST = 1'b1;
    dmemREN_EX_MEM = 1'b1; #1;
    chk("dw0", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    chk("dw1", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    chk("dw2", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    dhit = 1'b1; #1;
    chk("dw3_dhit", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    dhit = 1'b0; #1;
    chk("dw4_adv", 32'(w_ctrl), 32'(C_ADV));
    tick();
`ifdef PIPE_CTRL_STATS_EN
    chk("cnt_dw", 32'(stall_cnt), 32'd4);
`endif
    dmemREN_EX_MEM = 1'b0; #1;
    chk("dw_after", 32'(w_ctrl), 32'(C_ADV));

    // dhit and ihit together: advance, completion flag nets to zero
    dmemWEN_EX_MEM = 1'b1; dhit = 1'b1; #1;
    chk("st_hit", 32'(w_ctrl), 32'(C_ADV));
    tick();
    dhit = 1'b0; #1;
    chk("st_next_miss", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    dhit = 1'b1; tick();
    dhit = 1'b0; #1;
    chk("st_done_adv", 32'(w_ctrl), 32'(C_ADV));
    tick();
    dmemWEN_EX_MEM = 1'b0;

    // HALT behind a pending load: no halt until it completes and advances
    dmemREN_EX_MEM = 1'b1; halt_MEM = 1'b1; #1;
    chk("hlt_dw", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    chk("hlt_dw_flag", 32'(halt), 32'd0);
    dhit = 1'b1; tick();
    dhit = 1'b0; #1;
    chk("hlt_adv", 32'(w_ctrl), 32'(C_ADV));
    tick();
    dmemREN_EX_MEM = 1'b0; halt_MEM = 1'b0; #1;
    chk("hlt_flag", 32'(halt), 32'd1);
    chk("hlt_ctrl", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    chk("hlt_sticky", 32'(halt), 32'd1);
    chk("hlt_ctrl2", 32'(w_ctrl), 32'(C_FRZ));

    // Reset leaves HALTED
    nRST = 1'b0; #1;
    chk("hrst_ctrl", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    nRST = 1'b1; #1;
    chk("hrst_halt", 32'(halt), 32'd0);
    chk("hrst_run", 32'(w_ctrl), 32'(C_ADV));

`ifdef PIPE_CTRL_STATS_EN
    // Saturation of a 4-bit counter
    nRST = 1'b0; tick(); nRST = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_sat", 32'(stall_cnt), 32'd15);
    nRST = 1'b0; tick(); nRST = 1'b1;
    chk("cnt_clr", 32'(stall_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
